// File: rtl/alu_rs_exec.sv
// ALU reservation station with a single-cycle execute stage and a registered result port.
// Define ALU_RS_FLUSH_EN to let `flush` squash every entry and the result register.
module alu_rs_exec #(
    parameter int RS_DEPTH  = 8,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 4,
    parameter int CDB_PORTS = 2,
    parameter int OP_W      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    output logic                          issue_ready,
    input  logic [OP_W-1:0]               issue_op,
    input  logic [TAG_W-1:0]              issue_dest,
    input  logic [TAG_W-1:0]              issue_tag1,
    input  logic [TAG_W-1:0]              issue_tag2,
    input  logic [DATA_W-1:0]             issue_data1,
    input  logic [DATA_W-1:0]             issue_data2,
    input  logic [CDB_PORTS-1:0]          cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0]    cdb_tag,
    input  logic [CDB_PORTS*DATA_W-1:0]   cdb_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [TAG_W-1:0]              out_tag,
    output logic [DATA_W-1:0]             out_data,
    input  logic                          flush
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int SHW   = $clog2(DATA_W);
    localparam int TD_W  = TAG_W + DATA_W;

    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(5);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(9);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_LUI  = OP_W'(11);

    logic [RS_DEPTH-1:0] r_busy;
    logic [OP_W-1:0]     r_op    [RS_DEPTH];
    logic [TAG_W-1:0]    r_dest  [RS_DEPTH];
    logic [TAG_W-1:0]    r_tag1  [RS_DEPTH];
    logic [TAG_W-1:0]    r_tag2  [RS_DEPTH];
    logic [DATA_W-1:0]   r_data1 [RS_DEPTH];
    logic [DATA_W-1:0]   r_data2 [RS_DEPTH];
    logic                r_out_valid;
    logic [TAG_W-1:0]    r_out_tag;
    logic [DATA_W-1:0]   r_out_data;

    logic [RS_DEPTH-1:0] w_ready;
    logic [IDX_W-1:0]    w_sel, w_free;
    logic                w_sel_v, w_can, w_disp, w_issue_acc, w_flush;
    logic [TD_W-1:0]     w_wk1 [RS_DEPTH];
    logic [TD_W-1:0]     w_wk2 [RS_DEPTH];
    logic [TD_W-1:0]     w_is1, w_is2;

`ifdef ALU_RS_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = flush & 1'b0;
`endif

    // Returns {tag, data}; lowest matching channel wins because it is assigned last.
    function automatic logic [TD_W-1:0] snoop(
        input logic [TAG_W-1:0]            tag,
        input logic [DATA_W-1:0]           data,
        input logic [CDB_PORTS-1:0]        cv,
        input logic [CDB_PORTS*TAG_W-1:0]  ct,
        input logic [CDB_PORTS*DATA_W-1:0] cd
    );
        logic [TD_W-1:0] res;
        res = {tag, data};
        if (tag != '0) begin
            for (int k = CDB_PORTS - 1; k >= 0; k--) begin
                if (cv[k] && ct[k*TAG_W +: TAG_W] == tag)
                    res = {{TAG_W{1'b0}}, cd[k*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] alu(
        input logic [OP_W-1:0]   op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] sa, sb;
        logic [SHW-1:0]           sh;
        logic [DATA_W-1:0]        res;
        sa = $signed(a);
        sb = $signed(b);
        sh = b[SHW-1:0];
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_SLL:  res = a << sh;
            OP_SLT:  res = {{(DATA_W-1){1'b0}}, (sa < sb)};
            OP_SLTU: res = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_XOR:  res = a ^ b;
            OP_SRL:  res = a >> sh;
            OP_SRA:  res = $unsigned(sa >>> sh);
            OP_OR:   res = a | b;
            OP_AND:  res = a & b;
            OP_LUI:  res = b;
            default: res = '0;
        endcase
        return res;
    endfunction

    always_comb begin
        w_sel   = '0;
        w_sel_v = 1'b0;
        w_free  = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            w_ready[i] = r_busy[i] && (r_tag1[i] == '0) && (r_tag2[i] == '0);
            w_wk1[i]   = snoop(r_tag1[i], r_data1[i], cdb_valid, cdb_tag, cdb_data);
            w_wk2[i]   = snoop(r_tag2[i], r_data2[i], cdb_valid, cdb_tag, cdb_data);
            if (w_ready[i]) begin
                w_sel   = IDX_W'(i);
                w_sel_v = 1'b1;
            end
            if (!r_busy[i])
                w_free = IDX_W'(i);
        end
    end

    assign issue_ready = ~&r_busy;
    assign w_can       = ~r_out_valid | out_ready;
    assign w_disp      = w_can & w_sel_v;
    assign w_issue_acc = issue_valid & issue_ready & (issue_op != OP_NOP) & ~w_flush;
    assign w_is1       = snoop(issue_tag1, issue_data1, cdb_valid, cdb_tag, cdb_data);
    assign w_is2       = snoop(issue_tag2, issue_data2, cdb_valid, cdb_tag, cdb_data);

    // Entry payload: written on issue, refreshed by wakeup while busy; validity lives in r_busy.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (w_issue_acc && w_free == IDX_W'(i)) begin
                r_op[i]                 <= issue_op;
                r_dest[i]               <= issue_dest;
                {r_tag1[i], r_data1[i]} <= w_is1;
                {r_tag2[i], r_data2[i]} <= w_is2;
            end else if (r_busy[i]) begin
                {r_tag1[i], r_data1[i]} <= w_wk1[i];
                {r_tag2[i], r_data2[i]} <= w_wk2[i];
            end
        end
    end

    // Execute stage boundary: the selected entry is computed and latched into the result register.
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_busy      <= '0;
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_data  <= '0;
        end else begin
            if (w_can) begin
                r_out_valid <= w_sel_v;
                if (w_sel_v) begin
                    r_out_tag  <= r_dest[w_sel];
                    r_out_data <= alu(r_op[w_sel], r_data1[w_sel], r_data2[w_sel]);
                end
            end
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (w_disp && w_sel == IDX_W'(i))
                    r_busy[i] <= 1'b0;
                else if (w_issue_acc && w_free == IDX_W'(i))
                    r_busy[i] <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_tag   = r_out_tag;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_alu_rs_exec.sv
// Self-checking bench for alu_rs_exec: directed scenarios plus randomized traffic against a station model.
module tb_alu_rs_exec;
    localparam int DEPTH = 8;
`ifdef ALU_RS_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, issue_valid, issue_ready, out_valid, out_ready, flush;
    logic [3:0]  issue_op, issue_dest, issue_tag1, issue_tag2, out_tag;
    logic [31:0] issue_data1, issue_data2, out_data;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_data;

    int checks = 0;
    int errors = 0;

    bit          m_busy [DEPTH];
    logic [3:0]  m_op [DEPTH], m_dest [DEPTH], m_t1 [DEPTH], m_t2 [DEPTH];
    logic [31:0] m_d1 [DEPTH], m_d2 [DEPTH];
    bit          m_ov;
    logic [3:0]  m_otag;
    logic [31:0] m_odata;

    alu_rs_exec #(.RS_DEPTH(8), .DATA_W(32), .TAG_W(4), .CDB_PORTS(2), .OP_W(4)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_dest(issue_dest), .issue_tag1(issue_tag1), .issue_tag2(issue_tag2),
        .issue_data1(issue_data1), .issue_data2(issue_data2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
        .flush(flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd1:  return a + b;
            4'd2:  return a - b;
            4'd3:  return a << sh;
            4'd4:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5:  return (a < b) ? 32'd1 : 32'd0;
            4'd6:  return a ^ b;
            4'd7:  return a >> sh;
            4'd8:  return $signed(a) >>> sh;
            4'd9:  return a | b;
            4'd10: return a & b;
            4'd11: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic snoop(inout logic [3:0] t, inout logic [31:0] d);
        for (int k = 0; k < 2; k++) begin
            if (t != 4'd0 && cdb_valid[k] && cdb_tag[k*4 +: 4] == t) begin
                d = cdb_data[k*32 +: 32];
                t = 4'd0;
            end
        end
    endtask

    // Advances the station model by one clock using the inputs currently applied.
    task automatic model_step();
        int sel, fr;
        bit can;
        logic [3:0]  t;
        logic [31:0] d;
        if (rst || (FLUSH_EN && flush)) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_ov = 1'b0; m_otag = 4'd0; m_odata = 32'd0;
            return;
        end
        sel = -1; fr = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel < 0 && m_busy[i] && m_t1[i] == 0 && m_t2[i] == 0) sel = i;
            if (fr < 0 && !m_busy[i]) fr = i;
        end
        can = !m_ov || out_ready;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_busy[i]) begin
                t = m_t1[i]; d = m_d1[i]; snoop(t, d); m_t1[i] = t; m_d1[i] = d;
                t = m_t2[i]; d = m_d2[i]; snoop(t, d); m_t2[i] = t; m_d2[i] = d;
            end
        end
        if (can) begin
            if (sel >= 0) begin
                m_ov = 1'b1;
                m_otag = m_dest[sel];
                m_odata = ref_alu(m_op[sel], m_d1[sel], m_d2[sel]);
                m_busy[sel] = 1'b0;
            end else begin
                m_ov = 1'b0;
            end
        end
        if (issue_valid && issue_op != 4'd0 && fr >= 0) begin
            m_busy[fr] = 1'b1; m_op[fr] = issue_op; m_dest[fr] = issue_dest;
            t = issue_tag1; d = issue_data1; snoop(t, d); m_t1[fr] = t; m_d1[fr] = d;
            t = issue_tag2; d = issue_data2; snoop(t, d); m_t2[fr] = t; m_d2[fr] = d;
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_op = 4'd0; issue_dest = 4'd0;
        issue_tag1 = 4'd0; issue_tag2 = 4'd0; issue_data1 = 32'd0; issue_data2 = 32'd0;
        cdb_valid = 2'b00; cdb_tag = 8'd0; cdb_data = 64'd0; flush = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] dest, input logic [3:0] t1,
                         input logic [31:0] d1, input logic [3:0] t2, input logic [31:0] d2);
        issue_valid = 1'b1; issue_op = op; issue_dest = dest;
        issue_tag1 = t1; issue_data1 = d1; issue_tag2 = t2; issue_data2 = d2;
    endtask

    task automatic do_reset();
        idle();
        out_ready = 1'b1;
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_tag !== 4'd0) begin errors++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
    endtask

    task automatic test_add_latency();
        do_reset();
        issue(4'd1, 4'd6, 4'd0, 32'd5, 4'd0, 32'd7);
        cyc();
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_early: got %b want 0", out_valid); end
        cyc();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 32'd12) begin errors++; $display("FAIL add_data: got %0d want 12", out_data); end
        checks++; if (out_tag !== 4'd6) begin errors++; $display("FAIL add_tag: got %0d want 6", out_tag); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_cdb_wakeup();
        do_reset();
        issue(4'd2, 4'd2, 4'd3, 32'd0, 4'd0, 32'd4);
        cyc(); idle(); cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wake_blocked: got %b want 0", out_valid); end
        cdb_valid = 2'b10; cdb_tag = {4'd3, 4'd3}; cdb_data = {32'd10, 32'd99};
        cyc(); idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wake_early: got %b want 0", out_valid); end
        cyc();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wake_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 32'd6) begin errors++; $display("FAIL wake_ch1_data: got %0d want 6", out_data); end
        checks++; if (out_tag !== 4'd2) begin errors++; $display("FAIL wake_tag: got %0d want 2", out_tag); end
    endtask

    task automatic test_issue_bypass();
        do_reset();
        issue(4'd8, 4'd9, 4'd0, 32'h8000_0000, 4'd5, 32'd0);
        cdb_valid = 2'b11; cdb_tag = {4'd5, 4'd5}; cdb_data = {32'd1, 32'hFFFF_FFFF};
        cyc(); idle(); cyc();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bypass_sra: got %h want ffffffff", out_data); end
        checks++; if (out_tag !== 4'd9) begin errors++; $display("FAIL bypass_tag: got %0d want 9", out_tag); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            issue(4'd1, 4'(i + 1), 4'(i + 1), 32'd0, 4'd0, 32'(i * 10));
            cyc();
        end
        idle();
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", issue_ready); end
        issue(4'd1, 4'd15, 4'd0, 32'd1, 4'd0, 32'd1);
        cyc(); idle(); cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_dropped: got %b want 0", out_valid); end
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd3}; cdb_data = {32'd0, 32'd100};
        cyc(); idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_wake_early: got %b want 0", out_valid); end
        cyc();
        checks++; if (out_valid !== 1'b1 || out_tag !== 4'd3) begin errors++; $display("FAIL full_dispatch: got v=%b tag=%0d want v=1 tag=3", out_valid, out_tag); end
        checks++; if (out_data !== 32'd120) begin errors++; $display("FAIL full_data: got %0d want 120", out_data); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b want 1", issue_ready); end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        issue(4'd1, 4'd1, 4'd0, 32'd1, 4'd0, 32'd2);
        cyc();
        issue(4'd6, 4'd2, 4'd0, 32'hF0, 4'd0, 32'hFF);
        cyc(); idle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_tag !== 4'd1 || out_data !== 32'd3) begin
                errors++; $display("FAIL stall_hold: got v=%b tag=%0d data=%0d want v=1 tag=1 data=3", out_valid, out_tag, out_data);
            end
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        checks++; if (out_valid !== 1'b1 || out_tag !== 4'd2 || out_data !== 32'h0F) begin
            errors++; $display("FAIL stall_second: got v=%b tag=%0d data=%h want v=1 tag=2 data=0f", out_valid, out_tag, out_data);
        end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        issue(4'd1, 4'd1, 4'd0, 32'd2, 4'd0, 32'd3);
        cyc(); idle(); cyc();
        for (int i = 0; i < 4; i++) begin
            issue(4'd1, 4'(i + 2), 4'(i + 1), 32'd0, 4'd0, 32'(i));
            cyc();
        end
        issue(4'd1, 4'd7, 4'd0, 32'd4, 4'd0, 32'd4);
        flush = 1'b1;
        cyc(); idle();
        if (FLUSH_EN) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out: got %b want 0", out_valid); end
            checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", issue_ready); end
        end else begin
            checks++; if (out_valid !== 1'b1 || out_data !== 32'd5) begin
                errors++; $display("FAIL flush_ignored: got v=%b data=%0d want v=1 data=5", out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        cdb_valid = 2'b11; cdb_tag = {4'd2, 4'd1}; cdb_data = {32'd20, 32'd10};
        cyc();
        cdb_tag = {4'd4, 4'd3};
        for (int i = 0; i < 5; i++) begin
            cyc(); idle();
            checks++; if (out_valid !== m_ov || (m_ov && (out_tag !== m_otag || out_data !== m_odata))) begin
                errors++; $display("FAIL flush_after: got v=%b tag=%0d data=%0d want v=%b tag=%0d data=%0d", out_valid, out_tag, out_data, m_ov, m_otag, m_odata);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            idle();
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1)
                issue(4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)),
                      ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0, $urandom,
                      ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                      ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom);
            cdb_valid = 2'($urandom_range(0, 3));
            cdb_tag = {4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))};
            cdb_data = {$urandom, $urandom};
            flush = ($urandom_range(0, 49) == 0);
            cyc();
            checks++; if (issue_ready !== !(m_busy.and())) begin
                errors++; $display("FAIL rand_issue_ready cyc %0d: got %b", n, issue_ready);
            end
            checks++; if (out_valid !== m_ov) begin
                errors++; $display("FAIL rand_out_valid cyc %0d: got %b want %b", n, out_valid, m_ov);
            end
            if (m_ov) begin
                checks++; if (out_tag !== m_otag || out_data !== m_odata) begin
                    errors++; $display("FAIL rand_result cyc %0d: got tag=%0d data=%h want tag=%0d data=%h", n, out_tag, out_data, m_otag, m_odata);
                end
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        idle();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_ov = 1'b0; m_otag = 4'd0; m_odata = 32'd0;
        test_reset();
        test_add_latency();
        test_cdb_wakeup();
        test_issue_bypass();
        test_full();
        test_stall();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
